fdivsqrt_resq: RTL and testbench

Result queue directly downstream of the combined divide/sqrt unit, in the M stage. Captures each completed result: quotient mantissa, exponent, sticky bit, integer div/rem result, integer flag and destination tag. Presents results to the rounding/writeback consumer over a valid/ready handshake. Decouples divider completion from writeback backpressure and raises a stall request so the divider FSM does not start an operation the queue cannot hold.

---
 rtl/fdivsqrt_resq_pkg.sv | 20 ++
 rtl/fdivsqrt_resq_mem.sv | 31 +++
 rtl/fdivsqrt_resq.sv | 138 +++++++++++++
 tb/tb_fdivsqrt_resq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fdivsqrt_resq_pkg.sv
// Shared types for the divide/sqrt result queue: result record layout and queue depth.
package fdivsqrt_resq_pkg;

   localparam int P_DIVB     = 64;
   localparam int P_NE       = 11;
   localparam int P_XLEN     = 64;
   localparam int P_TAGW     = 5;
   localparam int RESQ_DEPTH = 2;

   // One completed divider result as stored in the queue, MSB field first.
   typedef struct packed {
      logic [P_DIVB:0]   Qm;
      logic [P_NE+1:0]   Qe;
      logic              Sticky;
      logic [P_XLEN-1:0] IntRes;
      logic              IsInt;
      logic [P_TAGW-1:0] Rd;
   } fdivres_t;

endpackage

// File: rtl/fdivsqrt_resq_mem.sv
// Queue storage: DEPTH words of W bits, one write port, one combinational read port.
module fdivsqrt_resq_mem #(
   parameter int DEPTH = 2,
   parameter int W     = 8,
   parameter int AW    = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_r [DEPTH];

   // Storage flops: cleared on reset so the head reads as zero, written on push.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {W{1'b0}};
         end
      end else if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/fdivsqrt_resq.sv
// Result queue behind the divide/sqrt unit: buffers completed results, presents
// the oldest one over valid/ready, and asks the divider to stall when it may not fit.
// Field widths follow the package record; the width parameters document the port sizes.
module fdivsqrt_resq
   import fdivsqrt_resq_pkg::*;
#(
   parameter int DIVb  = P_DIVB,
   parameter int NE    = P_NE,
   parameter int XLEN  = P_XLEN,
   parameter int DEPTH = RESQ_DEPTH,
   parameter int TAGW  = P_TAGW
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ResValidM,
   input  logic [DIVb:0]            QmM,
   input  logic [NE+1:0]            QeM,
   input  logic                     DivStickyM,
   input  logic [XLEN-1:0]          FIntDivResultM,
   input  logic                     IntDivM,
   input  logic [TAGW-1:0]          RdM,
   input  logic                     FlushQ,
   input  logic                     OutReady,
   output logic                     OutValid,
   output logic [DIVb:0]            OutQm,
   output logic [NE+1:0]            OutQe,
   output logic                     OutSticky,
   output logic [XLEN-1:0]          OutIntRes,
   output logic                     OutIsInt,
   output logic [TAGW-1:0]          OutRd,
   output logic                     StallReq,
   output logic [$clog2(DEPTH):0]   Count,
   output logic                     Overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int W  = $bits(fdivres_t);

   logic [AW-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_nxt, wr_ptr_nxt;
   logic [CW-1:0] count_r, count_nxt;
   logic          overflow_r, overflow_nxt;
   logic          push, pop, mem_we;
   fdivres_t      wr_rec, head_rec;
   logic [W-1:0]  rd_word;

   // Pack the incoming result fields into one storage word.
   always_comb begin
      wr_rec        = '0;
      wr_rec.Qm     = QmM;
      wr_rec.Qe     = QeM;
      wr_rec.Sticky = DivStickyM;
      wr_rec.IntRes = FIntDivResultM;
      wr_rec.IsInt  = IntDivM;
      wr_rec.Rd     = RdM;
   end

   // Handshake and next-state: a full queue still takes a push when the head
   // leaves in the same cycle; flush overrides everything except the sticky error.
   always_comb begin
      pop          = (count_r != {CW{1'b0}}) & OutReady;
      push         = ResValidM & ((count_r < CW'(DEPTH)) | pop);
      rd_ptr_nxt   = rd_ptr_r;
      wr_ptr_nxt   = wr_ptr_r;
      count_nxt    = count_r;
      overflow_nxt = overflow_r;
      mem_we       = 1'b0;
      if (FlushQ) begin
         rd_ptr_nxt = {AW{1'b0}};
         wr_ptr_nxt = {AW{1'b0}};
         count_nxt  = {CW{1'b0}};
      end else begin
         mem_we = push;
         if (push) begin
            wr_ptr_nxt = wr_ptr_r + AW'(1);
         end else begin
            wr_ptr_nxt = wr_ptr_r;
         end
         if (pop) begin
            rd_ptr_nxt = rd_ptr_r + AW'(1);
         end else begin
            rd_ptr_nxt = rd_ptr_r;
         end
         case ({push, pop})
            2'b10:   count_nxt = count_r + CW'(1);
            2'b01:   count_nxt = count_r - CW'(1);
            default: count_nxt = count_r;
         endcase
         if (ResValidM & ~push) begin
            overflow_nxt = 1'b1;
         end else begin
            overflow_nxt = overflow_r;
         end
      end
   end

   // Pointer, occupancy and error state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_r   <= {AW{1'b0}};
         wr_ptr_r   <= {AW{1'b0}};
         count_r    <= {CW{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         rd_ptr_r   <= rd_ptr_nxt;
         wr_ptr_r   <= wr_ptr_nxt;
         count_r    <= count_nxt;
         overflow_r <= overflow_nxt;
      end
   end

   fdivsqrt_resq_mem #(
      .DEPTH (DEPTH),
      .W     (W),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we),
      .waddr (wr_ptr_r),
      .wdata (wr_rec),
      .raddr (rd_ptr_r),
      .rdata (rd_word)
   );

   assign head_rec  = fdivres_t'(rd_word);
   assign OutValid  = (count_r != {CW{1'b0}});
   assign OutQm     = head_rec.Qm;
   assign OutQe     = head_rec.Qe;
   assign OutSticky = head_rec.Sticky;
   assign OutIntRes = head_rec.IntRes;
   assign OutIsInt  = head_rec.IsInt;
   assign OutRd     = head_rec.Rd;
   assign StallReq  = (count_r >= CW'(DEPTH - 1)) & ~pop;
   assign Count     = count_r;
   assign Overflow  = overflow_r;

endmodule

// File: tb/tb_fdivsqrt_resq.sv
// Directed bench for the divide/sqrt result queue.
module tb_fdivsqrt_resq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ResValidM = 1'b0;
   logic [64:0] QmM = 65'h0;
   logic [12:0] QeM = 13'h0;
   logic        DivStickyM = 1'b0;
   logic [63:0] FIntDivResultM = 64'h0;
   logic        IntDivM = 1'b0;
   logic [4:0]  RdM = 5'd0;
   logic        FlushQ = 1'b0;
   logic        OutReady = 1'b0;
   logic        OutValid;
   logic [64:0] OutQm;
   logic [12:0] OutQe;
   logic        OutSticky;
   logic [63:0] OutIntRes;
   logic        OutIsInt;
   logic [4:0]  OutRd;
   logic        StallReq;
   logic [1:0]  Count;
   logic        Overflow;

   int total = 0;
   int bad = 0;

   fdivsqrt_resq dut (
      .clk(clk), .reset(reset), .ResValidM(ResValidM), .QmM(QmM), .QeM(QeM),
      .DivStickyM(DivStickyM), .FIntDivResultM(FIntDivResultM), .IntDivM(IntDivM),
      .RdM(RdM), .FlushQ(FlushQ), .OutReady(OutReady), .OutValid(OutValid),
      .OutQm(OutQm), .OutQe(OutQe), .OutSticky(OutSticky), .OutIntRes(OutIntRes),
      .OutIsInt(OutIsInt), .OutRd(OutRd), .StallReq(StallReq), .Count(Count),
      .Overflow(Overflow)
   );

   always #5 clk = ~clk;

   // advance one clock, land 1ns after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ResValidM = 1'b0; IntDivM = 1'b0; FIntDivResultM = 64'h0; FlushQ = 1'b0;
      QmM = 65'h0; QeM = 13'h0; DivStickyM = 1'b0; RdM = 5'd0;
   endtask

   task automatic test_reset();
      reset = 1'b1; idle_inputs(); OutReady = 1'b0;
      step(); step();
      total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", OutValid); end
      total++; if (Count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", Count); end
      total++; if (StallReq !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", StallReq); end
      total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", Overflow); end
      total++; if (OutQm !== 65'h0) begin bad++; $display("FAIL reset_qm got=%h exp=0", OutQm); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_single();
      OutReady = 1'b1; ResValidM = 1'b1;
      QmM = 65'h1_8000_0000_0000_0000; QeM = 13'h3FF; DivStickyM = 1'b1; RdM = 5'd1;
      #1;
      total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL single_nobypass got=%b exp=0", OutValid); end
      step(); idle_inputs();
      total++; if (OutValid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", OutValid); end
      total++; if (OutQm !== 65'h1_8000_0000_0000_0000) begin bad++; $display("FAIL single_qm got=%h exp=18000000000000000", OutQm); end
      total++; if (OutQe !== 13'h3FF) begin bad++; $display("FAIL single_qe got=%h exp=3ff", OutQe); end
      total++; if (OutSticky !== 1'b1) begin bad++; $display("FAIL single_sticky got=%b exp=1", OutSticky); end
      total++; if (Count !== 2'd1) begin bad++; $display("FAIL single_count1 got=%0d exp=1", Count); end
      step();
      total++; if (Count !== 2'd0) begin bad++; $display("FAIL single_count0 got=%0d exp=0", Count); end
      total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL single_drained got=%b exp=0", OutValid); end
   endtask

   task automatic test_backpressure();
      OutReady = 1'b0;
      ResValidM = 1'b1; RdM = 5'd3; step();
      total++; if (StallReq !== 1'b1) begin bad++; $display("FAIL bp_stall1 got=%b exp=1", StallReq); end
      RdM = 5'd7; step(); idle_inputs();
      total++; if (Count !== 2'd2) begin bad++; $display("FAIL bp_count got=%0d exp=2", Count); end
      total++; if (StallReq !== 1'b1) begin bad++; $display("FAIL bp_stall2 got=%b exp=1", StallReq); end
      total++; if (OutRd !== 5'd3) begin bad++; $display("FAIL bp_head got=%0d exp=3", OutRd); end
      step();
      total++; if (OutRd !== 5'd3) begin bad++; $display("FAIL bp_hold got=%0d exp=3", OutRd); end
      OutReady = 1'b1; #1;
      total++; if (StallReq !== 1'b0) begin bad++; $display("FAIL bp_stall_pop got=%b exp=0", StallReq); end
      total++; if (OutRd !== 5'd3) begin bad++; $display("FAIL bp_drain_a got=%0d exp=3", OutRd); end
      step();
      total++; if (OutRd !== 5'd7) begin bad++; $display("FAIL bp_drain_b got=%0d exp=7", OutRd); end
      step();
      total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", OutValid); end
   endtask

   task automatic test_full_push_pop();
      OutReady = 1'b0;
      ResValidM = 1'b1; RdM = 5'd3; step();
      RdM = 5'd7; step();
      OutReady = 1'b1; RdM = 5'd9; #1;
      total++; if (OutRd !== 5'd3) begin bad++; $display("FAIL pp_head_a got=%0d exp=3", OutRd); end
      step(); idle_inputs();
      total++; if (Count !== 2'd2) begin bad++; $display("FAIL pp_count got=%0d exp=2", Count); end
      total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL pp_ovf got=%b exp=0", Overflow); end
      total++; if (OutRd !== 5'd7) begin bad++; $display("FAIL pp_head_b got=%0d exp=7", OutRd); end
      step();
      total++; if (OutRd !== 5'd9) begin bad++; $display("FAIL pp_head_c got=%0d exp=9", OutRd); end
      total++; if (Count !== 2'd1) begin bad++; $display("FAIL pp_count1 got=%0d exp=1", Count); end
      step();
      total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL pp_empty got=%b exp=0", OutValid); end
   endtask

   task automatic test_overflow_flush();
      OutReady = 1'b0;
      ResValidM = 1'b1; RdM = 5'd10; step();
      RdM = 5'd11; step();
      FlushQ = 1'b1; RdM = 5'd12; step(); idle_inputs();
      total++; if (Count !== 2'd0) begin bad++; $display("FAIL fl_prio_count got=%0d exp=0", Count); end
      total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL fl_prio_ovf got=%b exp=0", Overflow); end
      ResValidM = 1'b1; RdM = 5'd13; step();
      RdM = 5'd14; step();
      RdM = 5'd15; step(); idle_inputs();
      total++; if (Overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", Overflow); end
      total++; if (Count !== 2'd2) begin bad++; $display("FAIL ovf_count got=%0d exp=2", Count); end
      total++; if (OutRd !== 5'd13) begin bad++; $display("FAIL ovf_head got=%0d exp=13", OutRd); end
      FlushQ = 1'b1; step(); idle_inputs();
      total++; if (Count !== 2'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", Count); end
      total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", OutValid); end
      total++; if (Overflow !== 1'b1) begin bad++; $display("FAIL flush_ovf got=%b exp=1", Overflow); end
   endtask

   task automatic test_async_reset();
      OutReady = 1'b0;
      ResValidM = 1'b1; RdM = 5'd4; step(); idle_inputs();
      total++; if (Count !== 2'd1) begin bad++; $display("FAIL ar_pre_count got=%0d exp=1", Count); end
      #2 reset = 1'b1;
      #1;
      total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", OutValid); end
      total++; if (Count !== 2'd0) begin bad++; $display("FAIL ar_count got=%0d exp=0", Count); end
      total++; if (StallReq !== 1'b0) begin bad++; $display("FAIL ar_stall got=%b exp=0", StallReq); end
      total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL ar_ovf got=%b exp=0", Overflow); end
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_integer();
      OutReady = 1'b0;
      ResValidM = 1'b1; IntDivM = 1'b1; FIntDivResultM = 64'hFFFF_FFFF_FFFF_FFFF; RdM = 5'd31;
      step(); idle_inputs();
      total++; if (OutIsInt !== 1'b1) begin bad++; $display("FAIL int_flag got=%b exp=1", OutIsInt); end
      total++; if (OutIntRes !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL int_res got=%h exp=ffffffffffffffff", OutIntRes); end
      total++; if (OutRd !== 5'd31) begin bad++; $display("FAIL int_rd got=%0d exp=31", OutRd); end
      total++; if (OutSticky !== 1'b0) begin bad++; $display("FAIL int_sticky got=%b exp=0", OutSticky); end
      OutReady = 1'b1; step();
      total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL int_drain got=%b exp=0", OutValid); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_full_push_pop();
      test_overflow_flush();
      test_async_reset();
      test_integer();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
